// File: rtl/io_responder.sv
// ---------------------------------------------------------------------------
// io_responder
//
// Memory-mapped I/O target for the 16-bit bus processor. Decodes the reserved
// I/O addresses on the MAR/WrMem/DrMem interface and owns the board-facing
// registers: LEDR/LEDG outputs, four hex-digit nibbles, a synchronized switch
// value, debounced keys and a sticky key-press capture register (KCAP).
//
// Ports
//   clk      in   rising-edge processor clock
//   rst_n    in   asynchronous active-low reset
//   addr     in   byte address (MAR), full-width compare
//   wdata    in   bus write data
//   we       in   write strobe, sampled on rising clk
//   rdata    out  combinational read data for addr (16'hDEAD when unmapped)
//   sel      out  high when addr hits one of the six I/O addresses
//   key_raw  in   board keys, asynchronous, active-low
//   sw_raw   in   board switches, asynchronous
//   ledr     out  LEDR register
//   ledg     out  LEDG register
//   hex      out  four hex nibbles, [3:0] = HEX0
//   key_evt  out  OR of all KCAP bits
// ---------------------------------------------------------------------------
module io_responder #(
    parameter int unsigned      DBITS           = 16,
    parameter int unsigned      DEBOUNCE_CYCLES = 16,
    parameter logic [DBITS-1:0] ADDR_LEDR       = 16'h0F00,
    parameter logic [DBITS-1:0] ADDR_LEDG       = 16'h0F02,
    parameter logic [DBITS-1:0] ADDR_HEX        = 16'h0F04,
    parameter logic [DBITS-1:0] ADDR_KEY        = 16'h0FF0,
    parameter logic [DBITS-1:0] ADDR_SW         = 16'h0FF2,
    parameter logic [DBITS-1:0] ADDR_KCAP       = 16'h0FF4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DBITS-1:0] addr,
    input  logic [DBITS-1:0] wdata,
    input  logic             we,
    output logic [DBITS-1:0] rdata,
    output logic             sel,
    input  logic [3:0]       key_raw,
    input  logic [9:0]       sw_raw,
    output logic [9:0]       ledr,
    output logic [7:0]       ledg,
    output logic [15:0]      hex,
    output logic             key_evt
);

    localparam int unsigned   CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    // Synchronizers (keys inverted so 1 = pressed)
    logic [3:0]    key_s1;
    logic [3:0]    key_s2;
    logic [9:0]    sw_s1;
    logic [9:0]    sw_s2;

    // Debounce state
    logic [3:0]    key_deb;
    logic [CW-1:0] key_cnt [4];
    logic [3:0]    key_rise;

    // Capture register and write decode
    logic [3:0]    kcap;
    logic [3:0]    kcap_clr;
    logic          wr_ledr;
    logic          wr_ledg;
    logic          wr_hex;
    logic          wr_kcap;

    // -----------------------------------------------------------------------
    // Input synchronizers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_s1 <= '0;
            key_s2 <= '0;
            sw_s1  <= '0;
            sw_s2  <= '0;
        end else begin
            key_s1 <= ~key_raw;
            key_s2 <= key_s1;
            sw_s1  <= sw_raw;
            sw_s2  <= sw_s1;
        end
    end

    // -----------------------------------------------------------------------
    // Key debounce: a mismatch must persist for DEBOUNCE_CYCLES consecutive
    // edges; any return to a match restarts the count.
    // -----------------------------------------------------------------------
    always_comb begin
        key_rise = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            key_rise[i] = key_s2[i] & ~key_deb[i] & (key_cnt[i] == CNT_LAST);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_deb <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                key_cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (key_s2[i] == key_deb[i]) begin
                    key_cnt[i] <= '0;
                end else if (key_cnt[i] == CNT_LAST) begin
                    key_deb[i] <= key_s2[i];
                    key_cnt[i] <= '0;
                end else begin
                    key_cnt[i] <= key_cnt[i] + CW'(1);
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Write decode and writable registers
    // -----------------------------------------------------------------------
    always_comb begin
        wr_ledr  = we && (addr == ADDR_LEDR);
        wr_ledg  = we && (addr == ADDR_LEDG);
        wr_hex   = we && (addr == ADDR_HEX);
        wr_kcap  = we && (addr == ADDR_KCAP);
        kcap_clr = wr_kcap ? wdata[3:0] : 4'b0000;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ledr <= '0;
            ledg <= '0;
            hex  <= '0;
            kcap <= '0;
        end else begin
            if (wr_ledr) ledr <= wdata[9:0];
            if (wr_ledg) ledg <= wdata[7:0];
            if (wr_hex)  hex  <= wdata[15:0];
            // Clear applied first so a same-edge press keeps the bit set
            kcap <= (kcap & ~kcap_clr) | key_rise;
        end
    end

    assign key_evt = |kcap;

    // -----------------------------------------------------------------------
    // Combinational read mux
    // -----------------------------------------------------------------------
    always_comb begin
        rdata = DBITS'(16'hDEAD);
        sel   = 1'b0;
        if (addr == ADDR_LEDR) begin
            rdata       = '0;
            rdata[9:0]  = ledr;
            sel         = 1'b1;
        end else if (addr == ADDR_LEDG) begin
            rdata       = '0;
            rdata[7:0]  = ledg;
            sel         = 1'b1;
        end else if (addr == ADDR_HEX) begin
            rdata       = '0;
            rdata[15:0] = hex;
            sel         = 1'b1;
        end else if (addr == ADDR_KEY) begin
            rdata       = '0;
            rdata[3:0]  = key_deb;
            sel         = 1'b1;
        end else if (addr == ADDR_SW) begin
            rdata       = '0;
            rdata[9:0]  = sw_s2;
            sel         = 1'b1;
        end else if (addr == ADDR_KCAP) begin
            rdata       = '0;
            rdata[3:0]  = kcap;
            sel         = 1'b1;
        end
    end

endmodule

// File: tb/tb_io_responder.sv
// ---------------------------------------------------------------------------
// tb_io_responder
//
// Directed bench for io_responder. Stimulus pushes expected responses into a
// scoreboard queue and fires an event; a separate monitor pops and compares
// against the DUT outputs.
// ---------------------------------------------------------------------------
module tb_io_responder;

    logic        clk;
    logic        rst_n;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        we;
    logic [15:0] rdata;
    logic        sel;
    logic [3:0]  key_raw;
    logic [9:0]  sw_raw;
    logic [9:0]  ledr;
    logic [7:0]  ledg;
    logic [15:0] hex;
    logic        key_evt;

    io_responder #(
        .DBITS           (16),
        .DEBOUNCE_CYCLES (16)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .addr    (addr),
        .wdata   (wdata),
        .we      (we),
        .rdata   (rdata),
        .sel     (sel),
        .key_raw (key_raw),
        .sw_raw  (sw_raw),
        .ledr    (ledr),
        .ledg    (ledg),
        .hex     (hex),
        .key_evt (key_evt)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // kind: 0 = rdata/sel, 1 = ledr, 2 = ledg, 3 = hex, 4 = key_evt
    typedef struct {
        int          kind;
        logic [15:0] exp;
        logic        exp_sel;
        string       name;
    } exp_t;

    exp_t sb[$];
    event sample_ev;
    int   checks   = 0;
    int   failures = 0;

    // Monitor
    always @(sample_ev) begin
        while (sb.size() > 0) begin
            exp_t it;
            logic [15:0] act;
            logic        ok;
            it = sb.pop_front();
            checks++;
            case (it.kind)
                0:       begin act = rdata;              ok = (rdata === it.exp) && (sel === it.exp_sel); end
                1:       begin act = {6'd0, ledr};       ok = (act === it.exp); end
                2:       begin act = {8'd0, ledg};       ok = (act === it.exp); end
                3:       begin act = hex;                ok = (act === it.exp); end
                default: begin act = {15'd0, key_evt};   ok = (act === it.exp); end
            endcase
            if (!ok) begin
                failures++;
                if (it.kind == 0)
                    $display("FAIL %s: got rdata=%h sel=%b, expected rdata=%h sel=%b",
                             it.name, rdata, sel, it.exp, it.exp_sel);
                else
                    $display("FAIL %s: got %h, expected %h", it.name, act, it.exp);
            end
        end
    end

    task automatic push(input int kind, input logic [15:0] exp,
                        input logic exp_sel, input string name);
        exp_t it;
        it.kind = kind; it.exp = exp; it.exp_sel = exp_sel; it.name = name;
        #1;
        sb.push_back(it);
        -> sample_ev;
        #1;
    endtask

    task automatic rd(input logic [15:0] a, input logic [15:0] exp,
                      input logic exp_sel, input string name);
        addr = a;
        push(0, exp, exp_sel, name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        tick();
        we    = 1'b0;
    endtask

    // Watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        rst_n   = 1'b0;
        addr    = 16'h0000;
        wdata   = 16'h0000;
        we      = 1'b0;
        key_raw = 4'hF;
        sw_raw  = 10'h000;

        // Reset state
        tick();
        push(1, 16'h0000, 1'b0, "reset_ledr");
        push(4, 16'h0000, 1'b0, "reset_key_evt");
        rd(16'h0F00, 16'h0000, 1'b1, "reset_rd_ledr");
        rd(16'h1234, 16'hDEAD, 1'b0, "unmapped_1234");
        tick();
        rst_n = 1'b1;
        tick();

        // Register read/write
        wr(16'h0F02, 16'hFFA5);
        push(2, 16'h00A5, 1'b0, "ledg_out");
        rd(16'h0F02, 16'h00A5, 1'b1, "ledg_rd");
        wr(16'h0F00, 16'hFFFF);
        push(1, 16'h03FF, 1'b0, "ledr_out");
        rd(16'h0F00, 16'h03FF, 1'b1, "ledr_rd");
        wr(16'h0F04, 16'hBEEF);
        push(3, 16'hBEEF, 1'b0, "hex_out");
        rd(16'h0F04, 16'hBEEF, 1'b1, "hex_rd");
        wr(16'h0FF2, 16'hFFFF);
        rd(16'h0FF2, 16'h0000, 1'b1, "sw_write_ignored");
        wr(16'h0FF0, 16'hFFFF);
        rd(16'h0FF0, 16'h0000, 1'b1, "key_write_ignored");
        rd(16'h0F01, 16'hDEAD, 1'b0, "unmapped_0F01");
        rd(16'h0FF6, 16'hDEAD, 1'b0, "unmapped_0FF6");

        // Switches: two-edge latency
        sw_raw = 10'h2AA;
        rd(16'h0FF2, 16'h0000, 1'b1, "sw_before_N");
        tick();
        rd(16'h0FF2, 16'h0000, 1'b1, "sw_after_N");
        tick();
        rd(16'h0FF2, 16'h02AA, 1'b1, "sw_after_N1");

        // KEY1 bounce: 10 low, 3 high, then steady low
        key_raw[1] = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        key_raw[1] = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        rd(16'h0FF0, 16'h0000, 1'b1, "bounce_rejected");
        key_raw[1] = 1'b0;
        for (int j = 1; j <= 17; j++) begin
            tick();
            rd(16'h0FF0, 16'h0000, 1'b1, $sformatf("key1_wait_%0d", j));
        end
        tick();
        rd(16'h0FF0, 16'h0002, 1'b1, "key1_pressed");
        rd(16'h0FF4, 16'h0002, 1'b1, "kcap_key1");
        push(4, 16'h0001, 1'b0, "key_evt_key1");

        // KEY0 press -> KCAP = 3
        key_raw[0] = 1'b0;
        for (int j = 1; j <= 17; j++) tick();
        rd(16'h0FF0, 16'h0002, 1'b1, "key0_not_yet");
        tick();
        rd(16'h0FF0, 16'h0003, 1'b1, "key0_pressed");
        rd(16'h0FF4, 16'h0003, 1'b1, "kcap_both");

        // W1C bit 0
        wr(16'h0FF4, 16'h0001);
        rd(16'h0FF4, 16'h0002, 1'b1, "kcap_w1c_bit0");
        push(4, 16'h0001, 1'b0, "key_evt_after_w1c");

        // KEY1 release: KEY drops after 2+D edges, KCAP unchanged
        key_raw[1] = 1'b1;
        for (int j = 1; j <= 17; j++) tick();
        rd(16'h0FF0, 16'h0003, 1'b1, "key1_release_wait");
        tick();
        rd(16'h0FF0, 16'h0001, 1'b1, "key1_released");
        rd(16'h0FF4, 16'h0002, 1'b1, "kcap_after_release");

        // KEY1 re-press with a clear on the same edge: set wins
        key_raw[1] = 1'b0;
        for (int j = 1; j <= 17; j++) tick();
        wr(16'h0FF4, 16'h0002);
        rd(16'h0FF0, 16'h0003, 1'b1, "key1_repressed");
        rd(16'h0FF4, 16'h0002, 1'b1, "kcap_set_wins");
        wr(16'h0FF4, 16'h0002);
        rd(16'h0FF4, 16'h0000, 1'b1, "kcap_cleared");
        push(4, 16'h0000, 1'b0, "key_evt_cleared");

        // Release and re-press KEY0 to get KCAP bit 0 set before reset
        key_raw[0] = 1'b1;
        for (int j = 1; j <= 18; j++) tick();
        rd(16'h0FF0, 16'h0002, 1'b1, "key0_released");
        key_raw[0] = 1'b0;
        for (int j = 1; j <= 18; j++) tick();
        rd(16'h0FF4, 16'h0001, 1'b1, "kcap_key0_again");
        push(4, 16'h0001, 1'b0, "key_evt_pre_reset");
        push(1, 16'h03FF, 1'b0, "ledr_pre_reset");

        // Mid-run asynchronous reset: effect is immediate
        rst_n = 1'b0;
        push(1, 16'h0000, 1'b0, "midreset_ledr");
        push(4, 16'h0000, 1'b0, "midreset_key_evt");
        push(2, 16'h0000, 1'b0, "midreset_ledg");
        push(3, 16'h0000, 1'b0, "midreset_hex");
        rd(16'h0FF4, 16'h0000, 1'b1, "midreset_kcap");
        rd(16'h0FF0, 16'h0000, 1'b1, "midreset_key");
        rd(16'h0FF2, 16'h0000, 1'b1, "midreset_sw");
        rd(16'h0F00, 16'h0000, 1'b1, "midreset_rd_ledr");
        rd(16'h1234, 16'hDEAD, 1'b0, "midreset_unmapped");
        tick();
        rst_n = 1'b1;
        tick();

        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
